lane_feeder: RTL
================

LANE_FEEDER -- requirements
Module: lane_feeder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port lane_valid, input, 1 bit: lane_data is valid.
REQ-004 SHALL have port lane_data, input, 12 bits: one 12-bit lane.
REQ-005 SHALL have port lane_ready, output, 1 bit: the block accepts a lane this cycle.
REQ-006 SHALL have port cmd_valid, input, 1 bit: a shift command is presented.
REQ-007 SHALL have port cmd_shift, input, 3 bits: lane shift amount; legal range 0..5.
REQ-008 SHALL have port cmd_fill, input, 12 bits: lane value shifted in.
REQ-009 SHALL have port cmd_ready, output, 1 bit: the block accepts a command this cycle.
REQ-010 SHALL have port op_valid, output, 1 bit: the operand bundle to the downstream lane shifter is valid.
REQ-011 SHALL have port op_ready, input, 1 bit: the downstream stage takes the bundle.
REQ-012 SHALL have port op_in, output, 96 bits: 8-lane window.
REQ-013 SHALL have port op_shift, output, 3 bits: registered command shift.
REQ-014 SHALL have port op_fill, output, 12 bits: registered command fill.
REQ-015 SHALL have port err_shift, output, 1 bit: one-cycle pulse when an illegal command is rejected.

Function
REQ-016 SHALL hold an 8-lane window register and a lane count in the range 0..8.
REQ-017 SHALL drive lane_ready = (count < 8).
REQ-018 SHALL transfer a lane when lane_valid and lane_ready are both high, writing it to window bits [12k+11:12k] with k = count, then incrementing count. The first lane goes to lane 0 (bits 11:0).
REQ-019 SHALL drive cmd_ready = (count == 8) and (op_valid is low or op_ready is high).
REQ-020 SHALL accept a command when cmd_valid and cmd_ready are both high.
REQ-021 For an accepted command with cmd_shift <= 5, SHALL on the next cycle set op_valid = 1, op_in = window, op_shift = cmd_shift and op_fill = cmd_fill, and clear count to 0. Latency from command accept to op_valid is 1 cycle.
REQ-022 For an accepted command with cmd_shift of 6 or 7, SHALL pulse err_shift high for exactly one cycle, leave op_* unchanged, and keep the window and count (count stays 8).
REQ-023 SHALL hold op_valid, op_in, op_shift and op_fill stable while op_valid is high and op_ready is low.
REQ-024 SHALL clear op_valid on the cycle after an op_valid && op_ready handshake, unless a legal command is accepted in the same cycle; in that case it reloads op_* and keeps op_valid high, giving back-to-back issue.
REQ-025 SHALL let the window refill with new lanes while a previous bundle is stalled at the output; the op register and the window register are independent.
REQ-026 SHALL NOT accept a lane and a command in the same cycle; this follows from the mutually exclusive count conditions.
REQ-027 SHALL ignore lane_valid while count == 8 and cmd_valid while cmd_ready is low, with no state change.

Reset
REQ-028 SHALL, while rst is high at a clock edge, set count = 0, window = 0, op_valid = 0, op_in = 0, op_shift = 0, op_fill = 0 and err_shift = 0.
REQ-029 SHALL, when reset is asserted mid-operation, discard any partial window and any pending bundle. lane_ready SHALL be 1 and cmd_ready SHALL be 0 on the first cycle after reset.

Configuration
REQ-030 With macro LANE_FEEDER_ERRCNT_EN defined, SHALL add output err_cnt (8 bits, reset 0), which increments on each err_shift pulse and saturates at 255.
REQ-031 Without LANE_FEEDER_ERRCNT_EN, SHALL have no err_cnt port and no counter logic; all other behaviour is identical.

Verification
REQ-032 Reset, then feed lanes 0x001..0x008 with op_ready = 1, then a command shift = 2, fill = 0xABC -> one cycle later op_valid = 1, op_in = 0x008_007_006_005_004_003_002_001, op_shift = 2, op_fill = 0xABC; next cycle op_valid = 0 and lane_ready = 1.
REQ-033 Full window, command shift = 6 -> err_shift high for 1 cycle, op_valid stays 0, cmd_ready stays 1; then command shift = 0 issues the original window unchanged.
REQ-034 Hold op_ready = 0 after an issue, feed 8 new lanes 0x100..0x107 -> op_* stable throughout, lane_ready = 0 after the 8th lane, cmd_ready = 0; raising op_ready together with a command shift = 5 -> back-to-back bundle, op_valid never drops.
REQ-035 Assert rst after 5 lanes have been written and while a bundle is pending -> op_valid = 0, lane_ready = 1, and the next 8 lanes form a fresh window starting at lane 0.
REQ-036 With LANE_FEEDER_ERRCNT_EN defined, issue 260 illegal commands (shift = 7) -> err_cnt = 255; a following reset returns err_cnt to 0.

Source files
------------

// File: rtl/lane_feeder.sv
// lane_feeder
//   Collects eight 12-bit lanes into a window register, then turns the
//   full window plus a shift command into an operand bundle for a
//   downstream lane shifter.
//
//   Ports
//     clk, rst                 clock and synchronous active-high reset
//     lane_valid/lane_data     lane input (12 bits), lane_ready when count < 8
//     cmd_valid/cmd_shift/     shift command (shift legal 0..5), cmd_ready when
//       cmd_fill                 the window is full and the op slot is free
//     op_valid/op_ready/       registered operand bundle: 96-bit window,
//       op_in/op_shift/op_fill   shift amount and fill value
//     err_shift                one-cycle pulse for a rejected (shift 6/7) command
//     err_cnt                  (only with LANE_FEEDER_ERRCNT_EN) saturating
//                              8-bit count of err_shift pulses
//
//   Optional feature macro: LANE_FEEDER_ERRCNT_EN
module lane_feeder (
  input  logic        clk,
  input  logic        rst,
  input  logic        lane_valid,
  input  logic [11:0] lane_data,
  output logic        lane_ready,
  input  logic        cmd_valid,
  input  logic [2:0]  cmd_shift,
  input  logic [11:0] cmd_fill,
  output logic        cmd_ready,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [95:0] op_in,
  output logic [2:0]  op_shift,
  output logic [11:0] op_fill,
`ifdef LANE_FEEDER_ERRCNT_EN
  output logic [7:0]  err_cnt,
`endif
  output logic        err_shift
);

  logic [3:0]  count_reg;
  logic [11:0] window_reg [8];
  logic [95:0] window_flat;

  logic        op_valid_reg;
  logic [95:0] op_in_reg;
  logic [2:0]  op_shift_reg;
  logic [11:0] op_fill_reg;
  logic        err_shift_reg;

  logic lane_fire;
  logic cmd_fire;
  logic cmd_legal;

  assign lane_ready = (count_reg < 4'd8);
  // The op slot is free when empty or when its bundle leaves this cycle.
  assign cmd_ready  = (count_reg == 4'd8) && (!op_valid_reg || op_ready);
  assign lane_fire  = lane_valid && lane_ready;
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign cmd_legal  = (cmd_shift <= 3'd5);

  // One register per lane slot; the slot selected by count takes the lane.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      always_ff @(posedge clk) begin
        if (rst) begin
          window_reg[gi] <= '0;
        end else if (lane_fire && (count_reg == 4'(gi))) begin
          window_reg[gi] <= lane_data;
        end
      end
      assign window_flat[12*gi +: 12] = window_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (cmd_fire && cmd_legal) begin
      count_reg <= '0;
    end else if (lane_fire) begin
      count_reg <= count_reg + 4'd1;
    end
  end

  // Operand register: a legal command reloads it (even while the previous
  // bundle is being taken), otherwise a handshake empties it.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_valid_reg  <= 1'b0;
      op_in_reg     <= '0;
      op_shift_reg  <= '0;
      op_fill_reg   <= '0;
      err_shift_reg <= 1'b0;
    end else begin
      err_shift_reg <= cmd_fire && !cmd_legal;
      if (cmd_fire && cmd_legal) begin
        op_valid_reg <= 1'b1;
        op_in_reg    <= window_flat;
        op_shift_reg <= cmd_shift;
        op_fill_reg  <= cmd_fill;
      end else if (op_valid_reg && op_ready) begin
        op_valid_reg <= 1'b0;
      end
    end
  end

  assign op_valid  = op_valid_reg;
  assign op_in     = op_in_reg;
  assign op_shift  = op_shift_reg;
  assign op_fill   = op_fill_reg;
  assign err_shift = err_shift_reg;

`ifdef LANE_FEEDER_ERRCNT_EN
  logic [7:0] err_cnt_reg;

  // Counts on the same edge that raises err_shift; sticks at 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_reg <= '0;
    end else if (cmd_fire && !cmd_legal && (err_cnt_reg != 8'hFF)) begin
      err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign err_cnt = err_cnt_reg;
`endif

endmodule
